// File: rtl/ysyx_22041211_wbu_pkg.sv
// Shared constants for the write-back unit: CSR addresses, reset values and FSM states.
package ysyx_22041211_wbu_pkg;

    localparam int unsigned GPR_ADDR_LEN = 5;
    localparam int unsigned GPR_NUM      = 32;
    localparam int unsigned CSR_AW       = 12;
    localparam int unsigned CNT_LEN      = 32;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    // MPP = machine mode after reset
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WRITE = 2'd1,
        WB_DONE  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/ysyx_22041211_wbu_regfile.sv
// General-purpose register file: two combinational read ports, one write port, x0 reads as zero.
module ysyx_22041211_RegisterFile
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [GPR_ADDR_LEN-1:0] waddr,
    input  logic [DATA_LEN-1:0]     wdata,
    input  logic [GPR_ADDR_LEN-1:0] raddr1,
    output logic [DATA_LEN-1:0]     rdata1,
    input  logic [GPR_ADDR_LEN-1:0] raddr2,
    output logic [DATA_LEN-1:0]     rdata2
);

    logic [DATA_LEN-1:0] regs [GPR_NUM];

    // Synchronous clear on reset; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(GPR_NUM); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports straight from the array, index 0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
    end

endmodule

// File: rtl/ysyx_22041211_wbu.sv
// Write-back unit: holds one LSU result, commits GPR/CSR writes, pulses commit to the IFU.
module ysyx_22041211_wbu
    import ysyx_22041211_wbu_pkg::*;
#(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned CSR_ADDR_LEN = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lsu_valid_i,
    output logic                    wb_ready_o,
    input  logic                    wd_i,
    input  logic [GPR_ADDR_LEN-1:0] wreg_i,
    input  logic [DATA_LEN-1:0]     wdata_i,
    input  logic                    csr_wen_i,
    input  logic [CSR_ADDR_LEN-1:0] csr_waddr_i,
    input  logic [DATA_LEN-1:0]     csr_wdata_i,
    input  logic [GPR_ADDR_LEN-1:0] raddr1_i,
    input  logic [GPR_ADDR_LEN-1:0] raddr2_i,
    output logic [DATA_LEN-1:0]     rdata1_o,
    output logic [DATA_LEN-1:0]     rdata2_o,
    input  logic [CSR_ADDR_LEN-1:0] csr_raddr_i,
    output logic [DATA_LEN-1:0]     csr_rdata_o,
    output logic                    wb_valid_o,
    output logic [CNT_LEN-1:0]      commit_cnt_o
);

    localparam logic [CSR_ADDR_LEN-1:0] A_MSTATUS = CSR_ADDR_LEN'(CSR_MSTATUS);
    localparam logic [CSR_ADDR_LEN-1:0] A_MTVEC   = CSR_ADDR_LEN'(CSR_MTVEC);
    localparam logic [CSR_ADDR_LEN-1:0] A_MEPC    = CSR_ADDR_LEN'(CSR_MEPC);
    localparam logic [CSR_ADDR_LEN-1:0] A_MCAUSE  = CSR_ADDR_LEN'(CSR_MCAUSE);

    wb_state_t                 state;
    logic                      hold_wd;
    logic [GPR_ADDR_LEN-1:0]   hold_wreg;
    logic [DATA_LEN-1:0]       hold_wdata;
    logic                      hold_csr_wen;
    logic [CSR_ADDR_LEN-1:0]   hold_csr_waddr;
    logic [DATA_LEN-1:0]       hold_csr_wdata;

    logic [DATA_LEN-1:0]       mstatus;
    logic [DATA_LEN-1:0]       mtvec;
    logic [DATA_LEN-1:0]       mepc;
    logic [DATA_LEN-1:0]       mcause;

    logic                      gpr_we;
    logic                      csr_we;

    // Held writes only fire during the WRITE cycle, so reset there discards them
    always_comb begin
        gpr_we = (state == WB_WRITE) && hold_wd;
        csr_we = (state == WB_WRITE) && hold_csr_wen;
    end

    // FSM, holding registers, handshake outputs and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WB_IDLE;
            wb_ready_o     <= 1'b1;
            wb_valid_o     <= 1'b0;
            commit_cnt_o   <= '0;
            hold_wd        <= 1'b0;
            hold_wreg      <= '0;
            hold_wdata     <= '0;
            hold_csr_wen   <= 1'b0;
            hold_csr_waddr <= '0;
            hold_csr_wdata <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (lsu_valid_i) begin
                        hold_wd        <= wd_i;
                        hold_wreg      <= wreg_i;
                        hold_wdata     <= wdata_i;
                        hold_csr_wen   <= csr_wen_i;
                        hold_csr_waddr <= csr_waddr_i;
                        hold_csr_wdata <= csr_wdata_i;
                        state          <= WB_WRITE;
                        wb_ready_o     <= 1'b0;
                    end
                end
                WB_WRITE: begin
                    state      <= WB_DONE;
                    wb_valid_o <= 1'b1;
                end
                WB_DONE: begin
                    state        <= WB_IDLE;
                    wb_valid_o   <= 1'b0;
                    wb_ready_o   <= 1'b1;
                    commit_cnt_o <= commit_cnt_o + CNT_LEN'(1);
                end
                default: begin
                    state      <= WB_IDLE;
                    wb_valid_o <= 1'b0;
                    wb_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Machine CSR file; writes to unimplemented addresses are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus <= DATA_LEN'(MSTATUS_RST);
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (csr_we) begin
            case (hold_csr_waddr)
                A_MSTATUS: mstatus <= hold_csr_wdata;
                A_MTVEC:   mtvec   <= hold_csr_wdata;
                A_MEPC:    mepc    <= hold_csr_wdata;
                A_MCAUSE:  mcause  <= hold_csr_wdata;
                default:   ;
            endcase
        end
    end

    // Combinational CSR read, zero for unimplemented addresses
    always_comb begin
        csr_rdata_o = '0;
        case (csr_raddr_i)
            A_MSTATUS: csr_rdata_o = mstatus;
            A_MTVEC:   csr_rdata_o = mtvec;
            A_MEPC:    csr_rdata_o = mepc;
            A_MCAUSE:  csr_rdata_o = mcause;
            default:   csr_rdata_o = '0;
        endcase
    end

    ysyx_22041211_RegisterFile #(
        .DATA_LEN (DATA_LEN)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (gpr_we),
        .waddr  (hold_wreg),
        .wdata  (hold_wdata),
        .raddr1 (raddr1_i),
        .rdata1 (rdata1_o),
        .raddr2 (raddr2_i),
        .rdata2 (rdata2_o)
    );

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
// Randomized self-checking bench for the write-back unit against an architectural model.
module tb_ysyx_22041211_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid_i;
    logic        wb_ready_o;
    logic        wd_i;
    logic [4:0]  wreg_i;
    logic [31:0] wdata_i;
    logic        csr_wen_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic [4:0]  raddr1_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        wb_valid_o;
    logic [31:0] commit_cnt_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural model state
    logic [31:0] m_gpr [32];
    logic [31:0] m_csr [int];
    logic [31:0] m_cnt;

    ysyx_22041211_wbu #(
        .DATA_LEN     (32),
        .CSR_ADDR_LEN (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid_i  (lsu_valid_i),
        .wb_ready_o   (wb_ready_o),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .csr_wen_i    (csr_wen_i),
        .csr_waddr_i  (csr_waddr_i),
        .csr_wdata_i  (csr_wdata_i),
        .raddr1_i     (raddr1_i),
        .raddr2_i     (raddr2_i),
        .rdata1_o     (rdata1_o),
        .rdata2_o     (rdata2_o),
        .csr_raddr_i  (csr_raddr_i),
        .csr_rdata_o  (csr_rdata_o),
        .wb_valid_o   (wb_valid_o),
        .commit_cnt_o (commit_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_gpr_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : m_gpr[idx];
    endfunction

    function automatic logic [31:0] m_csr_rd(input logic [11:0] addr);
        return m_csr.exists(int'(addr)) ? m_csr[int'(addr)] : 32'h0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_csr.delete();
        m_csr[32'h300] = 32'h0000_1800;
        m_csr[32'h305] = 32'h0;
        m_csr[32'h341] = 32'h0;
        m_csr[32'h342] = 32'h0;
        m_cnt = 32'h0;
    endfunction

    function automatic void m_commit(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                                     input logic cwen, input logic [11:0] caddr, input logic [31:0] cdata);
        if (wd && wreg != 5'd0) m_gpr[wreg] = wdata;
        if (cwen && m_csr.exists(int'(caddr))) m_csr[int'(caddr)] = cdata;
    endfunction

    // Read-port spot check while idle
    task automatic peek(input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] ca);
        @(negedge clk);
        raddr1_i    = r1;
        raddr2_i    = r2;
        csr_raddr_i = ca;
        #1;
        check("peek_rd1", rdata1_o, m_gpr_rd(r1));
        check("peek_rd2", rdata2_o, m_gpr_rd(r2));
        check("peek_csr", csr_rdata_o, m_csr_rd(ca));
    endtask

    // One LSU result through the unit; optional busy-time pulse and mid-write reset
    task automatic txn(input logic wd, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic cwen, input logic [11:0] caddr, input logic [31:0] cdata,
                       input bit busy, input bit rst_mid);
        logic [4:0] r2;
        r2 = 5'($urandom_range(0, 31));
        @(negedge clk);
        check("idle_ready", 32'(wb_ready_o), 32'd1);
        lsu_valid_i = 1'b1;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        csr_wen_i = cwen; csr_waddr_i = caddr; csr_wdata_i = cdata;
        raddr1_i = wreg; raddr2_i = r2; csr_raddr_i = caddr;
        @(negedge clk);
        lsu_valid_i = busy;
        if (busy) begin
            wd_i = 1'b1; wreg_i = 5'd6; wdata_i = 32'hAA;
            csr_wen_i = 1'b1; csr_waddr_i = 12'h305; csr_wdata_i = 32'hBAD0;
        end
        check("write_ready", 32'(wb_ready_o), 32'd0);
        check("write_valid", 32'(wb_valid_o), 32'd0);
        check("nobypass_rd1", rdata1_o, m_gpr_rd(wreg));
        check("nobypass_csr", csr_rdata_o, m_csr_rd(caddr));
        if (rst_mid) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            lsu_valid_i = 1'b0;
            m_reset();
            check("rst_valid", 32'(wb_valid_o), 32'd0);
            check("rst_ready", 32'(wb_ready_o), 32'd1);
            check("rst_cnt", commit_cnt_o, m_cnt);
            check("rst_rd1", rdata1_o, m_gpr_rd(wreg));
            check("rst_csr", csr_rdata_o, m_csr_rd(caddr));
            @(negedge clk);
            check("rst_valid2", 32'(wb_valid_o), 32'd0);
            check("rst_cnt2", commit_cnt_o, m_cnt);
            return;
        end
        m_commit(wd, wreg, wdata, cwen, caddr, cdata);
        @(negedge clk);
        check("done_valid", 32'(wb_valid_o), 32'd1);
        check("done_ready", 32'(wb_ready_o), 32'd0);
        check("done_rd1", rdata1_o, m_gpr_rd(wreg));
        check("done_rd2", rdata2_o, m_gpr_rd(r2));
        check("done_csr", csr_rdata_o, m_csr_rd(caddr));
        check("done_cnt", commit_cnt_o, m_cnt);
        @(negedge clk);
        lsu_valid_i = 1'b0;
        m_cnt = m_cnt + 32'd1;
        check("idle_valid", 32'(wb_valid_o), 32'd0);
        check("idle_ready2", 32'(wb_ready_o), 32'd1);
        check("idle_cnt", commit_cnt_o, m_cnt);
    endtask

    initial begin
        logic [11:0] csr_pick [5];
        logic [11:0] ca;
        csr_pick[0] = 12'h300; csr_pick[1] = 12'h305; csr_pick[2] = 12'h341;
        csr_pick[3] = 12'h342; csr_pick[4] = 12'h7C0;

        rst = 1'b1; lsu_valid_i = 1'b0; wd_i = 1'b0; wreg_i = '0; wdata_i = '0;
        csr_wen_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
        raddr1_i = '0; raddr2_i = '0; csr_raddr_i = 12'h300;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_ready", 32'(wb_ready_o), 32'd1);
        check("reset_valid", 32'(wb_valid_o), 32'd0);
        check("reset_cnt", commit_cnt_o, 32'd0);
        check("reset_mstatus", csr_rdata_o, 32'h0000_1800);
        peek(5'd5, 5'd31, 12'h341);

        // Directed scenarios
        txn(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        txn(1'b1, 5'd0, 32'h12345678, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        txn(1'b1, 5'd3, 32'h0000_1800, 1'b1, 12'h341, 32'h8000_0010, 1'b0, 1'b0);
        txn(1'b1, 5'd9, 32'h0000_0123, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        peek(5'd6, 5'd9, 12'h305);
        txn(1'b0, 5'd1, 32'h0, 1'b1, 12'h7C0, 32'h0000_FFFF, 1'b0, 1'b0);
        peek(5'd0, 5'd3, 12'h300);
        peek(5'd5, 5'd3, 12'h341);
        txn(1'b1, 5'd7, 32'h55, 1'b0, 12'h000, 32'h0, 1'b0, 1'b1);
        peek(5'd7, 5'd5, 12'h341);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            ca = csr_pick[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) ca = 12'($urandom);
            txn(1'($urandom), 5'($urandom), $urandom, 1'($urandom), ca, $urandom,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            if ((n % 10) == 0) peek(5'($urandom), 5'($urandom), csr_pick[$urandom_range(0, 4)]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
